change_dispenser: RTL

- Downstream stage of the vending controller. It consumes the product code (PO) and change amount (MO) that the vending block produces.
- On each new vend it releases the item for one cycle, then pays out the change as individual coins to a coin hopper over a valid/ready handshake.
- It selects coins greedily (50/10/5/1) against per-denomination stock counters and reports any shortfall when stock runs out.

---
 rtl/change_dispenser.sv | 131 +++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: releases the vended item for one cycle, then pays the change
// greedily (50/10/5/1) to a coin hopper over valid/ready, tracking per-coin stock.
module change_dispenser #(
  parameter int N50_INIT = 4,
  parameter int N10_INIT = 8,
  parameter int N5_INIT  = 8,
  parameter int N1_INIT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] PO,
  input  logic [7:0] MO,
  input  logic       refill,
  input  logic       coin_ready,
  output logic [1:0] item,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] short
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VEND = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state_reg, state_next;
  logic [7:0] rem_reg, rem_next;
  logic [1:0] prod_reg;
  logic [1:0] po_d_reg;
  logic [7:0] stock_reg [4];
  logic [7:0] stock_init [4];
  logic [7:0] coin_value [4];
  logic [3:0] usable;
  logic [1:0] coin_sel;
  logic       coin_any;
  logic       accept;
  logic       take;

  // Stock and value tables are indexed by coin_type (0=1, 1=5, 2=10, 3=50).
  assign stock_init[0] = 8'(N1_INIT);
  assign stock_init[1] = 8'(N5_INIT);
  assign stock_init[2] = 8'(N10_INIT);
  assign stock_init[3] = 8'(N50_INIT);
  assign coin_value[0] = 8'd1;
  assign coin_value[1] = 8'd5;
  assign coin_value[2] = 8'd10;
  assign coin_value[3] = 8'd50;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_denom
      assign usable[gi] = (stock_reg[gi] != 8'd0) && (coin_value[gi] <= rem_reg);
    end
  endgenerate

  // Largest usable denomination wins.
  always_comb begin
    coin_sel = 2'd0;
    coin_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (usable[i]) begin
        coin_sel = 2'(i);
        coin_any = 1'b1;
      end
    end
  end

  assign accept     = (state_reg == IDLE) && (PO != 2'd0) && (PO != po_d_reg);
  assign coin_valid = (state_reg == PAY) && coin_any;
  assign coin_type  = coin_valid ? coin_sel : 2'd0;
  assign take       = coin_valid && coin_ready;
  assign item       = (state_reg == VEND) ? prod_reg : 2'd0;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          rem_next   = MO;
          state_next = VEND;
        end
      end
      VEND: state_next = (rem_reg != 8'd0) ? PAY : DONE;
      PAY: begin
        if (!coin_any) begin
          state_next = DONE;
        end else if (coin_ready) begin
          rem_next = rem_reg - coin_value[coin_sel];
          if (rem_next == 8'd0) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      rem_reg   <= 8'd0;
      prod_reg  <= 2'd0;
      po_d_reg  <= 2'd0;
      err       <= 1'b0;
      short     <= 8'd0;
      for (int i = 0; i < 4; i++) stock_reg[i] <= stock_init[i];
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      po_d_reg  <= PO;
      if (accept) begin
        prod_reg <= PO;
        err      <= 1'b0;
        short    <= 8'd0;
      end else if (state_reg == IDLE && refill) begin
        for (int i = 0; i < 4; i++) stock_reg[i] <= stock_init[i];
      end
      if (take) stock_reg[coin_sel] <= stock_reg[coin_sel] - 8'd1;
      // Result is latched on entry to DONE so it is already valid while done is high.
      if (state_next == DONE && state_reg != DONE) begin
        short <= rem_next;
        err   <= (rem_next != 8'd0);
      end
    end
  end

endmodule
